fetch_unit: RTL and testbench

Instruction fetch stage placed directly downstream of the program counter. It takes the current pc, runs a req/gnt/rvalid handshake with a variable-latency instruction memory, and holds the returned instruction until the decode stage accepts it. It drives fetch_stall back to the PC so the PC advances only when an instruction is consumed, or on a redirect. Redirects (taken branch, JAL, JALR) are signalled by flush and discard any in-flight fetch.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_timeout_ctr.sv | 16 +
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared states, fault causes and defaults for the fetch stage
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int TIMEOUT_W = 8;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT = 8'd255;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: clear/enable counter flagging the last cycle before LIMIT is reached
module fetch_timeout_ctr #(
  parameter int W = 8,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = en && cnt == LIMIT - 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with hold buffer, redirect drop and fault capture
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_stall,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);
  state_t state, state_n;
  logic [31:0] req_pc, cur_pc;
  logic req_new, drop, drop_n, tc, misalign;
  fetch_timeout_ctr #(.W(TIMEOUT_W), .LIMIT(TIMEOUT)) u_ctr (
    .clk(clk), .reset(reset), .clr(state != WAIT), .en(state == WAIT), .tc(tc)
  );
  // pc is sampled in the first REQ cycle, after the PC has already advanced or redirected
  assign cur_pc = req_new ? pc : req_pc;
  assign misalign = cur_pc[1:0] != 2'b00;
  assign imem_req = state == REQ && !misalign;
  assign imem_addr = state == REQ ? cur_pc : req_pc;
  assign instr_valid = state == HOLD;
  assign fetch_stall = reset || !((instr_valid && instr_ready) || flush);
  always_comb begin
    state_n = state;
    drop_n = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        state_n = misalign ? FAULT : imem_gnt ? WAIT : REQ;
        drop_n = !misalign && (drop || flush);
      end
      WAIT: begin
        state_n = imem_rvalid ? ((drop || flush) ? REQ : imem_err ? FAULT : HOLD) : tc ? FAULT : WAIT;
        drop_n = !imem_rvalid && !tc && (drop || flush);
      end
      HOLD: state_n = (instr_ready || flush) ? REQ : HOLD;
      FAULT: state_n = flush ? REQ : FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      req_pc <= '0;
      req_new <= 1'b0;
      drop <= 1'b0;
      instr <= NOP_INSTR;
      instr_pc <= '0;
      fetch_fault <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      state <= state_n;
      drop <= drop_n;
      req_new <= state_n == REQ && state != REQ;
      if (state == REQ) req_pc <= cur_pc;
      if (state == WAIT && state_n == HOLD) begin
        instr <= imem_rdata;
        instr_pc <= req_pc;
      end
      if (state == HOLD && state_n != HOLD) instr <= NOP_INSTR;
      if (state_n == FAULT && state != FAULT) begin
        fetch_fault <= 1'b1;
        fault_cause <= state == REQ ? CAUSE_MISALIGN : imem_rvalid ? CAUSE_BUSERR : CAUSE_TIMEOUT;
      end
      if (state == FAULT && flush) begin
        fetch_fault <= 1'b0;
        fault_cause <= CAUSE_NONE;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed literal checks plus randomized run against a transaction-level fetch model
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0, instr_ready = 1'b0;
  logic [31:0] pc = '0, imem_rdata = '0;
  logic imem_req, instr_valid, fetch_stall, fetch_fault;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [1:0] fault_cause;
  int n_vec = 0, n_err = 0;
  bit chk_en = 0;
  bit m_boot, m_issue, m_known, m_await, m_held, m_fault, m_discard;
  logic [1:0] m_cause;
  logic [31:0] m_addr, m_instr, m_ipc, ea;
  int m_elapsed, mem_lat;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_stall(fetch_stall), .fetch_fault(fetch_fault), .fault_cause(fault_cause)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Address the fetcher presents: the live pc until a request has sampled it, then the sampled one
  function automatic logic [31:0] m_cur();
    return (m_issue && !m_known) ? pc : m_addr;
  endfunction

  task automatic m_start();
    m_issue = 1; m_known = 0; m_discard = 0;
  endtask

  task automatic m_step();
    logic [31:0] a;
    a = m_cur();
    if (reset) begin
      m_boot = 1; m_issue = 0; m_known = 0; m_await = 0; m_held = 0; m_fault = 0;
      m_discard = 0; m_cause = 0; m_addr = 0; m_ipc = 0; m_instr = 0; m_elapsed = 0;
    end else if (m_boot) begin
      m_boot = 0; m_start();
    end else if (m_issue) begin
      m_addr = a; m_known = 1;
      if (a[1:0] != 2'b00) begin
        m_issue = 0; m_fault = 1; m_cause = 2'd1;
      end else begin
        m_discard = m_discard | flush;
        if (imem_gnt) begin m_issue = 0; m_await = 1; m_elapsed = 0; end
      end
    end else if (m_await) begin
      m_elapsed++;
      if (imem_rvalid) begin
        m_await = 0;
        if (m_discard || flush) m_start();
        else if (imem_err) begin m_fault = 1; m_cause = 2'd2; end
        else begin m_held = 1; m_instr = imem_rdata; m_ipc = m_addr; end
      end else if (m_elapsed == 255) begin
        m_await = 0; m_fault = 1; m_cause = 2'd3;
      end else m_discard = m_discard | flush;
    end else if (m_held) begin
      if (instr_ready || flush) begin m_held = 0; m_start(); end
    end else if (m_fault && flush) begin
      m_fault = 0; m_cause = 0; m_start();
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      ea = m_cur();
      chk("imem_req", 32'(imem_req), 32'(m_issue && ea[1:0] == 2'b00));
      chk("imem_addr", imem_addr, ea);
      chk("instr_valid", 32'(instr_valid), 32'(m_held));
      chk("instr", instr, m_held ? m_instr : NOP_INSTR);
      chk("instr_pc", instr_pc, m_ipc);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      chk("fault_cause", 32'(fault_cause), 32'(m_cause));
      chk("fetch_stall", 32'(fetch_stall), 32'(reset || !((m_held && instr_ready) || flush)));
    end
  end

  task automatic step(input logic r, input logic f, input logic rdy, input logic g, input logic rv,
                      input logic [31:0] rd, input logic e, input logic [31:0] p);
    @(negedge clk);
    reset = r; flush = f; instr_ready = rdy; imem_gnt = g; imem_rvalid = rv;
    imem_rdata = rd; imem_err = e; pc = p;
    #2 m_step();
  endtask

  logic r, f, rdy, g, rv, e, was, stall;
  logic [31:0] tgt, pc_reg;

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_stall", 32'(fetch_stall), 1);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 1, 0, 0, 0, 32'h0);
    chk("t1_req", 32'(imem_req), 1);
    chk("t1_addr", imem_addr, 32'h0);
    step(0, 0, 1, 0, 1, 32'h00500093, 0, 32'h0);
    chk("t1_wait_valid", 32'(instr_valid), 0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h0);
    chk("t1_valid", 32'(instr_valid), 1);
    chk("t1_instr", instr, 32'h00500093);
    chk("t1_ipc", instr_pc, 32'h0);
    chk("t1_stall", 32'(fetch_stall), 0);
    step(0, 0, 1, 1, 0, 0, 0, 32'h4);
    chk("t1_next_stall", 32'(fetch_stall), 1);
    chk("t1_next_instr", instr, 32'h00000013);
    chk("t1_next_addr", imem_addr, 32'h4);
    step(0, 0, 0, 0, 1, 32'h00a00113, 0, 32'h4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 32'h8);
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_instr", instr, 32'h00a00113);
      chk("bp_stall", 32'(fetch_stall), 1);
      chk("bp_req", 32'(imem_req), 0);
    end
    step(0, 0, 1, 0, 0, 0, 0, 32'h8);
    step(0, 0, 0, 0, 0, 0, 0, 32'h100);
    chk("gd_addr0", imem_addr, 32'h100);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 32'h300);
      chk("gd_req", 32'(imem_req), 1);
      chk("gd_addr", imem_addr, 32'h100);
    end
    step(0, 0, 0, 1, 0, 0, 0, 32'h300);
    chk("gd_addr_gnt", imem_addr, 32'h100);
    step(0, 1, 0, 0, 0, 0, 0, 32'h300);
    chk("fl_wait_req", 32'(imem_req), 0);
    chk("fl_stall", 32'(fetch_stall), 0);
    step(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h200);
    step(0, 0, 0, 1, 0, 0, 0, 32'h200);
    chk("fl_valid", 32'(instr_valid), 0);
    chk("fl_req", 32'(imem_req), 1);
    chk("fl_addr", imem_addr, 32'h200);
    step(0, 0, 0, 0, 1, 32'h00000113, 0, 32'h200);
    step(0, 0, 1, 0, 0, 0, 0, 32'h200);
    chk("fl_ipc", instr_pc, 32'h200);
    step(0, 0, 0, 1, 0, 0, 0, 32'h102);
    chk("ma_req", 32'(imem_req), 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h102);
    chk("ma_fault", 32'(fetch_fault), 1);
    chk("ma_cause", 32'(fault_cause), 1);
    step(0, 1, 0, 0, 0, 0, 0, 32'h102);
    step(0, 0, 0, 1, 0, 0, 0, 32'h104);
    chk("ma_clr", 32'(fetch_fault), 0);
    chk("ma_addr", imem_addr, 32'h104);
    repeat (254) step(0, 0, 0, 0, 0, 0, 0, 32'h104);
    step(0, 0, 0, 0, 0, 0, 0, 32'h104);
    chk("to_last_wait", 32'(fetch_fault), 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h104);
    chk("to_fault", 32'(fetch_fault), 1);
    chk("to_cause", 32'(fault_cause), 3);
    step(0, 1, 0, 0, 0, 0, 0, 32'h104);
    step(0, 0, 0, 1, 0, 0, 0, 32'h108);
    step(0, 0, 0, 0, 1, 32'h12345678, 1, 32'h108);
    step(0, 0, 0, 0, 0, 0, 0, 32'h108);
    chk("be_cause", 32'(fault_cause), 2);
    chk("be_valid", 32'(instr_valid), 0);
    step(0, 1, 0, 0, 0, 0, 0, 32'h108);
    step(0, 0, 0, 1, 0, 0, 0, 32'h10c);
    step(1, 0, 0, 0, 0, 0, 0, 32'h10c);
    step(0, 0, 0, 0, 1, 32'h00000BAD, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'h00000BAD, 0, 32'h0);
    chk("late_valid", 32'(instr_valid), 0);
    chk("late_req", 32'(imem_req), 1);
    pc_reg = 0;
    mem_lat = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 599) == 0;
      f = $urandom_range(0, 19) == 0;
      rdy = $urandom_range(0, 2) != 0;
      g = $urandom_range(0, 2) == 0;
      rv = m_await ? mem_lat == 0 : $urandom_range(0, 9) == 0;
      e = rv && $urandom_range(0, 15) == 0;
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      was = m_await;
      stall = r || !((m_held && rdy) || f);
      step(r, f, rdy, g, rv, $urandom, e, pc_reg);
      pc_reg = r ? 32'h0 : f ? tgt : stall ? pc_reg : pc_reg + 32'd4;
      if (m_await && !was) mem_lat = ($urandom_range(0, 39) == 0) ? 300 : int'($urandom_range(0, 3));
      else if (m_await && mem_lat > 0) mem_lat--;
    end
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
